// File: rtl/pipe_add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Optional feature macro: PIPE_ADD_SUB_FLAGS_EN (zero/neg/ovf flags).
package pipe_add_sub_pkg;

    // Operation select encoding on sub_i.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Result flags for the ALU / branch-compare path.
    typedef struct packed {
        logic carry;  // carry-out of MSB (subtract: 1 = no borrow)
        logic ovf;    // signed overflow
        logic zero;   // result == 0
        logic neg;    // result MSB
    } flags_t;

    // Width of one carry-chain slice; one slice per pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_add_sub_if.sv
// Operand/result handshake bundle for pipe_add_sub.
// Optional feature macro: PIPE_ADD_SUB_FLAGS_EN (affects only flag values).
//
// Handshake: a beat moves on either side exactly in a cycle where valid
// and ready are both high at the rising clock edge. A producer keeps
// valid and data stable until the beat moves; ready may depend
// combinationally on the opposite side's ready, never on the same
// side's valid.
interface pipe_add_sub_if #(
    parameter int WIDTH = 32
);
    import pipe_add_sub_pkg::*;

    // Operand side
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;

    // Result side
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             ovf_o;
    logic             zero_o;
    logic             neg_o;

    // Driver of operands / consumer of results.
    modport master (
        output in_valid_i, a_i, b_i, sub_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, carry_o, ovf_o, zero_o, neg_o
    );

    // The adder itself.
    modport slave (
        input  in_valid_i, a_i, b_i, sub_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, carry_o, ovf_o, zero_o, neg_o
    );

endinterface

// File: rtl/pipe_add_sub_add_slice.sv
// Combinational SW-bit ripple adder built from per-bit full-adder cells.
// Also exposes the carry into the MSB so the caller can form signed overflow.
// Optional feature macro: PIPE_ADD_SUB_FLAGS_EN (not used here).
module add_slice
    import pipe_add_sub_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    // c[i] is the carry into bit i; c[SW] is the slice carry-out.
    logic [SW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        // One full-adder cell: sum and majority carry.
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SW];
    assign cmsb = c[SW-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is
// cut into STAGES slices; slice k is added in stage k and its carry-out is
// registered for slice k+1. A single global advance signal moves every
// stage together, so bubbles are kept, ordering is trivially preserved and
// one op per cycle flows when the consumer keeps up.
// Optional feature macro: PIPE_ADD_SUB_FLAGS_EN builds zero/neg/ovf flags;
// without it those outputs are tied low and only sum_o/carry_o are live.
module pipe_add_sub
    import pipe_add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pipe_add_sub_if.slave bus
);

    localparam int SW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH)) begin : g_bad_stages
        $error("pipe_add_sub: STAGES must be in 1..WIDTH");
    end
    if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipe_add_sub: WIDTH must be a multiple of STAGES");
    end

    // Global advance: the whole pipe moves unless the output is stuck.
    logic adv;

    // Stage registers. a_q/b_q carry the operand slices not yet consumed,
    // s_q the sum bits already completed, c_q the carry out of the slice.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    // Per-stage sources (previous register, or the input port for stage 0)
    // and the combinational results that stage k loads.
    logic             v_src  [STAGES];
    logic [WIDTH-1:0] a_src  [STAGES];
    logic [WIDTH-1:0] b_src  [STAGES];
    logic [WIDTH-1:0] s_src  [STAGES];
    logic             c_src  [STAGES];
    logic [SW-1:0]    slc_sum[STAGES];
    logic [WIDTH-1:0] s_nxt  [STAGES];
    logic             c_nxt  [STAGES];
    logic             cm_nxt [STAGES];

    flags_t flags;

    assign adv            = !v_q[LAST] || bus.out_ready_i;
    assign bus.in_ready_o = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src_in
            // Subtract is A + ~B + 1: invert B and inject the +1 as cin.
            assign v_src[k] = bus.in_valid_i;
            assign a_src[k] = bus.a_i;
            assign b_src[k] = (bus.sub_i == OP_SUB) ? ~bus.b_i : bus.b_i;
            assign c_src[k] = bus.sub_i;
            assign s_src[k] = '0;
        end else begin : g_src_reg
            assign v_src[k] = v_q[k-1];
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign c_src[k] = c_q[k-1];
            assign s_src[k] = s_q[k-1];
        end

        add_slice #(
            .SW(SW)
        ) u_slice (
            .a    (a_src[k][k*SW +: SW]),
            .b    (b_src[k][k*SW +: SW]),
            .cin  (c_src[k]),
            .sum  (slc_sum[k]),
            .cout (c_nxt[k]),
            .cmsb (cm_nxt[k])
        );

        logic [WIDTH-1:0] s_merge;

        // Splice this slice's sum into the partial result from earlier stages.
        always_comb begin
            s_merge              = s_src[k];
            s_merge[k*SW +: SW]  = slc_sum[k];
        end

        assign s_nxt[k] = s_merge;
    end

    // Pipeline registers: flush on reset, shift together on advance. Data
    // only loads behind a valid beat so idle inputs never disturb the pipe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src[k];
                if (v_src[k]) begin
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    s_q[k] <= s_nxt[k];
                    c_q[k] <= c_nxt[k];
                end
            end
        end
    end

`ifdef PIPE_ADD_SUB_FLAGS_EN
    flags_t flags_q;

    // Flags are formed from the final slice and registered alongside sum_o.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flags_q <= '0;
        end else if (adv && v_src[LAST]) begin
            flags_q.carry <= c_nxt[LAST];
            flags_q.ovf   <= c_nxt[LAST] ^ cm_nxt[LAST];
            flags_q.zero  <= (s_nxt[LAST] == '0);
            flags_q.neg   <= s_nxt[LAST][WIDTH-1];
        end
    end

    assign flags = flags_q;
`else
    // Only the carry flag exists; the rest are constant zero.
    always_comb begin
        flags       = '0;
        flags.carry = c_q[LAST];
    end
`endif

    assign bus.out_valid_o = v_q[LAST];
    assign bus.sum_o       = s_q[LAST];
    assign bus.carry_o     = flags.carry;
    assign bus.ovf_o       = flags.ovf;
    assign bus.zero_o      = flags.zero;
    assign bus.neg_o       = flags.neg;

    // Operand slices already consumed and intermediate MSB carries are never
    // read; fold them here so they do not show up as dangling logic.
    logic unused_ok;

    // Reduction of otherwise unread pipeline bits.
    always_comb begin
        unused_ok = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_ok = unused_ok ^ (^{a_q[k], b_q[k], cm_nxt[k], c_q[k]});
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub (WIDTH=32, STAGES=4). Directed vectors with
// hand-computed results are pushed into exp_q as they are accepted; an
// independent monitor pops and compares whenever a result is drained.
// Optional feature macro: PIPE_ADD_SUB_FLAGS_EN changes expected flags.
module tb_pipe_add_sub;
    import pipe_add_sub_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int W      = WIDTH + 4;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    pipe_add_sub_if #(.WIDTH(WIDTH)) bus ();

    pipe_add_sub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int acc_cyc = 0;
    int first_acc = 0;
    int last_drain = 0;

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Pack an expected result; flags other than carry exist only with the macro.
    function automatic logic [W-1:0] mk(input logic [WIDTH-1:0] s, input logic c,
                                        input logic v, input logic z, input logic n);
`ifdef PIPE_ADD_SUB_FLAGS_EN
        return {s, c, v, z, n};
`else
        return {s, c, 1'b0, 1'b0, 1'b0};
`endif
    endfunction

    // ---------------- driver tasks (entered #1 after a posedge) ----------------
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input logic [W-1:0] exp);
        int n;
        bus.in_valid_i = 1'b1;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.sub_i      = sub;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready_o);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        acc_cyc        = cyc;
        bus.in_valid_i = 1'b0;
    endtask

    // Called right after send returns: the accept edge counts as cycle 1.
    task automatic measure_latency(input string name, input int required);
        int lat;
        lat = 1;
        while (!bus.out_valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, W'(lat), W'(required));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    task automatic stall3();
        int n;
        n = 0;
        while (!bus.out_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_start_valid", W'(bus.out_valid_o), W'(1));
        bus.out_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", W'(bus.in_ready_o), W'(0));
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic         held_v = 1'b0;
    logic [W-1:0] held_d = '0;

    always @(negedge clk) begin
        logic [W-1:0] got;
        got = {bus.sum_o, bus.carry_o, bus.ovf_o, bus.zero_o, bus.neg_o};
        if (!rst_ni) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", W'(bus.out_valid_o), W'(1));
                check("hold_data", got, held_d);
            end
            held_v = bus.out_valid_o && !bus.out_ready_i;
            held_d = got;
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got=%h expected=none", got);
                end else begin
                    check("result", got, exp_q.pop_front());
                end
                last_drain = cyc + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid_i  = 1'b1;
        bus.a_i         = 32'hDEAD_BEEF;
        bus.b_i         = 32'h1234_5678;
        bus.sub_i       = OP_ADD;
        bus.out_ready_i = 1'b1;

        // Reset held two cycles with valid high: nothing may enter.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid_o), W'(0));
        check("rst_sum", W'(bus.sum_o), W'(0));
        check("rst_flags", W'({bus.carry_o, bus.ovf_o, bus.zero_o, bus.neg_o}), W'(0));
        @(posedge clk);
        #1;
        rst_ni         = 1'b1;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", W'(bus.in_ready_o), W'(1));
        check("post_rst_out_valid", W'(bus.out_valid_o), W'(0));
        @(posedge clk);
        #1;

        // Carry ripples through every slice.
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, mk(32'h0000_0000, 1, 0, 1, 0));
        measure_latency("ripple_latency", STAGES);
        wait_drain();

        // Subtracts and signed overflow, back to back.
        send(32'd5, 32'd7, OP_SUB, mk(32'hFFFF_FFFE, 0, 0, 0, 1));
        send(32'd7, 32'd5, OP_SUB, mk(32'h0000_0002, 1, 0, 0, 0));
        send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, mk(32'h8000_0000, 0, 1, 0, 1));
        send(32'h8000_0000, 32'h0000_0001, OP_SUB, mk(32'h7FFF_FFFF, 1, 1, 0, 0));
        send(32'h0000_0000, 32'h0000_0000, OP_SUB, mk(32'h0000_0000, 1, 0, 1, 0));
        wait_drain();

        // Eight back-to-back ops with a 3-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(WIDTH'(i), WIDTH'(100 * i), OP_ADD,
                         mk(WIDTH'(101 * i), 0, 0, (i == 0), 0));
                    if (i == 0) first_acc = acc_cyc;
                end
            end
            stall3();
        join
        wait_drain();
        check("bp_total_cycles", W'(last_drain - first_acc + 1), W'(8 + 4 + 3));

        // Reset while three ops are in flight: they must vanish.
        send(32'h0000_0011, 32'h0000_0022, OP_ADD, mk(32'h0000_0033, 0, 0, 0, 0));
        send(32'h0000_0044, 32'h0000_0011, OP_SUB, mk(32'h0000_0033, 1, 0, 0, 0));
        send(32'h0000_0100, 32'h0000_0200, OP_ADD, mk(32'h0000_0300, 0, 0, 0, 0));
        rst_ni = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("flush_out_valid", W'(bus.out_valid_o), W'(0));
        end
        @(posedge clk);
        #1;
        send(32'h1234_5678, 32'h1111_1111, OP_ADD, mk(32'h2345_6789, 0, 0, 0, 0));
        measure_latency("post_flush_latency", STAGES);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
